acl2_reading_ascii_formatter: RTL and testbench

- Sits directly downstream of the PMOD ACL2 custom driver.
- Captures each 8-byte 3-axis-plus-temperature sample on its valid pulse.
- Formats the sample as one fixed-length ASCII hex text line.
- Streams the line byte by byte over a valid/ready handshake into the UART TX FIFO.

---
 rtl/acl2_reading_ascii_formatter.sv | 223 ++++++++++++++++++++++
 tb/tb_acl2_reading_ascii_formatter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acl2_reading_ascii_formatter.sv
// ACL2 sample-to-ASCII line formatter: latches an 8-byte XYZ+temperature sample and streams it
// as "X=hhhh Y=hhhh Z=hhhh T=hhhh" + CR LF / LF. Optional pending slot: ACL2_ASCII_PEND_EN.
module acl2_reading_ascii_formatter #(
  parameter bit parm_upper_hex = 1'b1,
  parameter bit parm_line_crlf = 1'b1
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic [63:0] i_data_3axis_temp,
  input  logic        i_data_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_line_done,
  output logic [7:0]  o_drop_count
);

  localparam logic [4:0] LAST_IDX = parm_line_crlf ? 5'd28 : 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_data, w_data_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic        r_tx_valid, w_tx_valid_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_line_done, w_line_done_nxt;
  logic [7:0]  r_drop_count, w_drop_count_nxt;
  logic        w_drop_inc;
  logic        w_cap;
  logic [63:0] w_cap_src;
  logic        w_hs;
`ifdef ACL2_ASCII_PEND_EN
  logic [63:0] r_pend_data, w_pend_data_nxt;
  logic        r_pend_full, w_pend_full_nxt;
`endif

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else if (parm_upper_hex) begin
      c = 8'h41 + {4'h0, n} - 8'h0A;
    end else begin
      c = 8'h61 + {4'h0, n} - 8'h0A;
    end
    return c;
  endfunction

  // Each field is 7 characters wide ("X=hhhh "), so the word is picked by index range
  function automatic logic [7:0] line_char(input logic [63:0] d, input logic [4:0] idx);
    logic [15:0] w;
    logic [7:0]  c;
    if (idx < 5'd7) begin
      w = {d[55:48], d[63:56]};
    end else if (idx < 5'd14) begin
      w = {d[39:32], d[47:40]};
    end else if (idx < 5'd21) begin
      w = {d[23:16], d[31:24]};
    end else begin
      w = {d[7:0], d[15:8]};
    end
    case (idx)
      5'd0:                       c = 8'h58;
      5'd7:                       c = 8'h59;
      5'd14:                      c = 8'h5A;
      5'd21:                      c = 8'h54;
      5'd1, 5'd8, 5'd15, 5'd22:   c = 8'h3D;
      5'd6, 5'd13, 5'd20:         c = 8'h20;
      5'd2, 5'd9, 5'd16, 5'd23:   c = nib2asc(w[15:12]);
      5'd3, 5'd10, 5'd17, 5'd24:  c = nib2asc(w[11:8]);
      5'd4, 5'd11, 5'd18, 5'd25:  c = nib2asc(w[7:4]);
      5'd5, 5'd12, 5'd19, 5'd26:  c = nib2asc(w[3:0]);
      5'd27:                      c = parm_line_crlf ? 8'h0D : 8'h0A;
      5'd28:                      c = 8'h0A;
      default:                    c = 8'h00;
    endcase
    return c;
  endfunction

  assign w_hs = r_tx_valid & i_tx_ready;

  // Next-state, capture and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_data_nxt      = r_data;
    w_idx_nxt       = r_idx;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = r_tx_valid;
    w_busy_nxt      = r_busy;
    w_line_done_nxt = 1'b0;
    w_drop_inc      = 1'b0;
    w_cap           = 1'b0;
    w_cap_src       = i_data_3axis_temp;
`ifdef ACL2_ASCII_PEND_EN
    w_pend_data_nxt = r_pend_data;
    w_pend_full_nxt = r_pend_full;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_data_valid) begin
          w_cap = 1'b1;
        end else begin
          w_cap = 1'b0;
        end
      end
      ST_SEND: begin
        if (w_hs && (r_idx == LAST_IDX)) begin
          w_state_nxt     = ST_DONE;
          w_tx_valid_nxt  = 1'b0;
          w_busy_nxt      = 1'b0;
          w_line_done_nxt = 1'b1;
        end else if (w_hs) begin
          w_idx_nxt     = r_idx + 5'd1;
          w_tx_data_nxt = line_char(r_data, r_idx + 5'd1);
        end else begin
          w_tx_valid_nxt = 1'b1;
        end
        if (i_data_valid) begin
`ifdef ACL2_ASCII_PEND_EN
          w_drop_inc      = r_pend_full;
          w_pend_data_nxt = i_data_3axis_temp;
          w_pend_full_nxt = 1'b1;
`else
          w_drop_inc = 1'b1;
`endif
        end else begin
          w_drop_inc = 1'b0;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
`ifdef ACL2_ASCII_PEND_EN
        if (r_pend_full) begin
          w_cap           = 1'b1;
          w_cap_src       = r_pend_data;
          w_pend_full_nxt = 1'b0;
          w_drop_inc      = i_data_valid;
        end else if (i_data_valid) begin
          w_cap = 1'b1;
        end else begin
          w_cap = 1'b0;
        end
`else
        if (i_data_valid) begin
          w_cap = 1'b1;
        end else begin
          w_cap = 1'b0;
        end
`endif
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_tx_valid_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
    endcase
    if (w_cap) begin
      w_state_nxt    = ST_SEND;
      w_data_nxt     = w_cap_src;
      w_idx_nxt      = 5'd0;
      w_tx_data_nxt  = line_char(w_cap_src, 5'd0);
      w_tx_valid_nxt = 1'b1;
      w_busy_nxt     = 1'b1;
    end else begin
      w_data_nxt = w_data_nxt;
    end
    if (w_drop_inc && (r_drop_count != 8'hFF)) begin
      w_drop_count_nxt = r_drop_count + 8'd1;
    end else begin
      w_drop_count_nxt = r_drop_count;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_state      <= ST_IDLE;
      r_data       <= 64'h0;
      r_idx        <= 5'd0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_line_done  <= 1'b0;
      r_drop_count <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_data       <= w_data_nxt;
      r_idx        <= w_idx_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_line_done  <= w_line_done_nxt;
      r_drop_count <= w_drop_count_nxt;
    end
  end

`ifdef ACL2_ASCII_PEND_EN
  // One-entry holding slot for a sample that arrives mid-line
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_pend_data <= 64'h0;
      r_pend_full <= 1'b0;
    end else begin
      r_pend_data <= w_pend_data_nxt;
      r_pend_full <= w_pend_full_nxt;
    end
  end
`endif

  assign o_tx_data    = r_tx_data;
  assign o_tx_valid   = r_tx_valid;
  assign o_busy       = r_busy;
  assign o_line_done  = r_line_done;
  assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_acl2_reading_ascii_formatter.sv
// Scoreboard bench for acl2_reading_ascii_formatter (default and lowercase/LF-only instances).
module tb_acl2_reading_ascii_formatter;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] din;
  logic        dv, rdy;
  logic [7:0]  txd, dcnt;
  logic        txv, busy, ldone;
  logic [63:0] b_din;
  logic        b_dv;
  logic        b_rdy = 1'b1;
  logic [7:0]  b_txd, b_dcnt;
  logic        b_txv, b_busy, b_ldone;

  int checks = 0;
  int failures = 0;

  bq_t exp_a, exp_b;
  int  m_left = 0;
  int  m_drop = 0;
  bit  m_done = 1'b0;
  bit  pend_full = 1'b0;
  logic [63:0] pend_d;
  bit  stall_v = 1'b0;
  logic [7:0] stall_d;

  acl2_reading_ascii_formatter u_dut (
    .i_clk_20mhz(clk), .i_rstn_20mhz(rstn), .i_data_3axis_temp(din), .i_data_valid(dv),
    .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(rdy), .o_busy(busy),
    .o_line_done(ldone), .o_drop_count(dcnt));

  acl2_reading_ascii_formatter #(.parm_upper_hex(1'b0), .parm_line_crlf(1'b0)) u_dut_lc (
    .i_clk_20mhz(clk), .i_rstn_20mhz(rstn), .i_data_3axis_temp(b_din), .i_data_valid(b_dv),
    .o_tx_data(b_txd), .o_tx_valid(b_txv), .i_tx_ready(b_rdy), .o_busy(b_busy),
    .o_line_done(b_ldone), .o_drop_count(b_dcnt));

  always #25 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Reference line text built straight from the field layout
  function automatic bq_t build(input logic [63:0] d, input bit up, input bit crlf);
    bq_t q;
    logic [15:0] w[4];
    logic [7:0]  nm[4];
    w[0] = {d[55:48], d[63:56]}; w[1] = {d[39:32], d[47:40]};
    w[2] = {d[23:16], d[31:24]}; w[3] = {d[7:0], d[15:8]};
    nm[0] = 8'h58; nm[1] = 8'h59; nm[2] = 8'h5A; nm[3] = 8'h54;
    q = {};
    for (int k = 0; k < 4; k++) begin
      if (k > 0) q.push_back(8'h20);
      q.push_back(nm[k]);
      q.push_back(8'h3D);
      for (int s = 12; s >= 0; s -= 4) q.push_back(hexc(w[k][s+:4], up));
    end
    if (crlf) q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference model and monitor for the default instance
  always @(negedge clk) begin
    if (!rstn) begin
      exp_a.delete(); m_left = 0; m_done = 1'b0; m_drop = 0; pend_full = 1'b0; stall_v = 1'b0;
    end else begin
      chk("busy", busy, m_left != 0);
      chk("tx_valid", txv, m_left != 0);
      chk("line_done", ldone, m_done);
      chk("drop_count", dcnt, sat(m_drop));
      if (stall_v) begin
        chk("stall_valid", txv, 1'b1);
        chk("stall_data", txd, stall_d);
      end
      stall_v = txv && !rdy;
      stall_d = txd;
      if (m_done && pend_full) begin
        exp_a = {exp_a, build(pend_d, 1'b1, 1'b1)};
        m_left = 29; pend_full = 1'b0;
        if (dv) m_drop++;
      end else if (dv) begin
        if (m_left == 0) begin
          exp_a = {exp_a, build(din, 1'b1, 1'b1)};
          m_left = 29;
        end else begin
`ifdef ACL2_ASCII_PEND_EN
          if (pend_full) m_drop++;
          pend_d = din; pend_full = 1'b1;
`else
          m_drop++;
`endif
        end
      end
      m_done = 1'b0;
      if (txv && rdy && m_left > 0) begin
        if (exp_a.size() == 0) chk("tx_byte_unexpected", txd, 8'h00);
        else chk("tx_byte", txd, exp_a.pop_front());
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end
  end

  // Monitor for the lowercase / LF-only instance (ready tied high)
  always @(negedge clk) begin
    if (!rstn) exp_b.delete();
    else if (b_txv) begin
      if (exp_b.size() == 0) chk("lc_byte_unexpected", b_txd, 8'h00);
      else chk("lc_byte", b_txd, exp_b.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [63:0] d);
    din = d; dv = 1'b1;
    cyc();
    dv = 1'b0; din = $urandom();
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((m_left != 0 || pend_full || m_done || exp_a.size() != 0) && n < 500) begin
      cyc(); n++;
    end
    chk({"timeout_", nm}, n < 500, 1'b1);
    cyc(); cyc();
  endtask

  initial begin
    int d0, n;
    rstn = 1'b0; dv = 1'b0; din = 64'h0; rdy = 1'b1; b_dv = 1'b0; b_din = 64'h0;
    #10;
    chk("rst_tx_data", txd, 8'h00);
    chk("rst_tx_valid", txv, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_line_done", ldone, 1'b0);
    chk("rst_drop", dcnt, 8'h00);
    chk("rst_lc_valid", b_txv, 1'b0);
    cyc(); cyc();
    rstn = 1'b1;
    cyc();

    // Full line with ready held high
    pulse(64'h3412_7856_BC9A_F0DE);
    wait_idle("line1");

    // Toggling ready, then a 5-cycle stall on the first Y digit
    pulse(64'h3412_7856_BC9A_F0DE);
    n = 0;
    while ((29 - exp_a.size()) < 9 && n < 200) begin
      rdy = ~rdy; cyc(); n++;
    end
    chk("timeout_toggle", n < 200, 1'b1);
    rdy = 1'b0;
    repeat (5) cyc();
    chk("stall_char", txd, 8'h35);
    chk("stall_hold_valid", txv, 1'b1);
    for (int c = 0; c < 60; c++) begin
      rdy = c[0]; cyc();
    end
    rdy = 1'b1;
    wait_idle("stall");

    // Three samples during a single line
    d0 = m_drop;
    pulse(64'h0102_0304_0506_0708);
    cyc(); cyc();
    pulse(64'h1111_2222_3333_4444); cyc();
    pulse(64'h5555_6666_7777_8888); cyc();
    pulse(64'h9999_AAAA_BBBB_CCCC);
    wait_idle("three");
`ifdef ACL2_ASCII_PEND_EN
    chk("three_drops", dcnt, d0 + 2);
`else
    chk("three_drops", dcnt, d0 + 3);
`endif

    // Lowercase, LF-only instance
    exp_b = {exp_b, build(64'hFFAB_0000_0000_0000, 1'b0, 1'b0)};
    chk("lc_len", exp_b.size(), 28);
    b_din = 64'hFFAB_0000_0000_0000; b_dv = 1'b1;
    cyc();
    b_dv = 1'b0;
    n = 0;
    while (exp_b.size() != 0 && n < 100) begin cyc(); n++; end
    chk("timeout_lc", n < 100, 1'b1);
    cyc(); cyc();
    chk("lc_idle", b_busy, 1'b0);
    chk("lc_drop", b_dcnt, 8'h00);

    // Reset in the middle of a line
    pulse(64'h0F1E_2D3C_4B5A_6978);
    repeat (10) cyc();
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", txv, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", ldone, 1'b0);
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
    pulse(64'hDEAD_BEEF_CAFE_F00D);
    wait_idle("after_rst");

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      din = {$urandom(), $urandom()};
      dv = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    dv = 1'b0; rdy = 1'b1;
    wait_idle("random");

    // Drop counter saturation
    rdy = 1'b0;
    for (int c = 0; c < 301; c++) begin
      din = {$urandom(), $urandom()}; dv = 1'b1; cyc();
    end
    dv = 1'b0; rdy = 1'b1;
    wait_idle("sat");
    chk("drop_sat", dcnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
